// File: rtl/furv_dbus.sv
// Data-side bus slave for the furv core: word-addressed data RAM plus an MMIO
// window holding a UART transmit FIFO/serialiser, a status register and a cycle counter.
module furv_dbus #(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_en,
  input  logic        core_read,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic          is_mmio;
  logic [1:0]    reg_sel;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign is_mmio = core_addr[31];
  assign reg_sel = core_addr[3:2];
  assign rd_req  = core_en & core_read;
  assign wr_req  = core_en & ~core_read;
  assign ram_idx = core_addr[AW+1:2];
  assign unused_addr_bits = ^{core_addr[30:AW+2], core_addr[1:0]};

  // ---------------- data RAM (registered read, no reset) ----------------
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_rd_reg;

  always_ff @(posedge clk) begin
    if (wr_req && !is_mmio) ram[ram_idx] <= core_wdata;
    if (rd_req && !is_mmio) ram_rd_reg <= ram[ram_idx];
  end

  // ---------------- cycle counter ----------------
  logic [31:0] cycle_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_reg <= '0;
    else if (wr_req && is_mmio && reg_sel == 2'd2)
      cycle_reg <= core_wdata;
    else
      cycle_reg <= cycle_reg + 32'd1;
  end

  // ---------------- UART TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_reg;
  logic [FW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          push_ok;
  logic          pop;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign push       = wr_req && is_mmio && reg_sel == 2'd0;
  assign push_ok    = push && !fifo_full;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= core_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + FW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + FW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      if (push && fifo_full)
        overflow_reg <= 1'b1;
      else if (wr_req && is_mmio && reg_sel == 2'd1 && core_wdata[2])
        overflow_reg <= 1'b0;
    end
  end

  // ---------------- UART serialiser ----------------
  uart_state_t   state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [2:0]    idx_inc;
  logic [7:0]    shifter_reg, shifter_next;
  logic          tx_reg, tx_next;

  assign idx_inc = bit_idx_reg + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shifter_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      shifter_reg <= shifter_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_idx_next = bit_idx_reg;
    shifter_next = shifter_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          shifter_next = fifo_mem[rd_ptr_reg];
          state_next   = START;
          tx_next      = 1'b0;
          timer_next   = TMAX;
        end
      end
      START: begin
        if (timer_reg == '0) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shifter_reg[0];
          timer_next   = TMAX;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      DATA: begin
        if (timer_reg == '0) begin
          timer_next = TMAX;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = idx_inc;
            tx_next      = shifter_reg[idx_inc];
          end
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      STOP: begin
        if (timer_reg == '0) state_next = IDLE;
        else                 timer_next = timer_reg - TW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  assign uart_tx = tx_reg;

  // ---------------- read path ----------------
  // CYCLE reads return the value the counter takes at the read edge.
  logic [31:0] mmio_rdata;
  logic [31:0] mmio_q_reg;
  logic        rd_ram_reg;

  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      2'd1:    mmio_rdata = {16'h0, 8'(count_reg), 5'b0, overflow_reg, fifo_full, fifo_empty};
      2'd2:    mmio_rdata = cycle_reg + 32'd1;
      default: mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ram_reg <= 1'b0;
      mmio_q_reg <= '0;
    end else if (rd_req) begin
      rd_ram_reg <= ~is_mmio;
      if (is_mmio) mmio_q_reg <= mmio_rdata;
    end
  end

  assign core_rdata = rd_ram_reg ? ram_rd_reg : mmio_q_reg;

endmodule

// File: tb/tb_furv_dbus.sv
// Scoreboard bench for furv_dbus: a frame/queue-level model predicts load data and
// the UART line level for every cycle; a monitor compares them against the DUT.
module tb_furv_dbus;

  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;
  localparam int CPB        = 4;

  logic        clk;
  logic        rst_n;
  logic        core_en;
  logic        core_read;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        uart_tx;

  furv_dbus #(
    .RAM_WORDS(RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .core_en(core_en),
    .core_read(core_read),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] rdq [$];
  logic        txq [$];

  // reference model state
  logic [31:0] mram [int];
  logic [7:0]  mq [$];
  logic        movf;
  logic [31:0] mcnt;
  logic [31:0] mrd;
  logic        mhas;
  logic [7:0]  mbyte;
  int          mfp;
  int          mn;

  function automatic int ram_key(input logic [31:0] a);
    return int'((a >> 2) & (RAM_WORDS - 1));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    int k;
    v = '0;
    if (!a[31]) begin
      k = ram_key(a);
      v = mram.exists(k) ? mram[k] : 32'hxxxx_xxxx;
    end else begin
      case (a[3:2])
        2'd1: v = {16'h0, 8'(mq.size()), 5'b0, movf, (mq.size() == FIFO_DEPTH), (mq.size() == 0)};
        2'd2: v = mcnt + 32'd1;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    movf = 1'b0;
    mcnt = '0;
    mrd  = '0;
    mhas = 1'b0;
    mbyte = '0;
    mfp  = 0;
    mn   = 0;
  endtask

  // one rising edge: pop decision and full check use the queue as it was before the edge
  task automatic model_edge(input logic en, input logic rd, input logic [31:0] a, input logic [31:0] wd);
    logic full_b;
    logic wr;
    mn++;
    wr = en && !rd;
    full_b = (mq.size() == FIFO_DEPTH);
    if (mq.size() > 0 && (!mhas || mn >= mfp + 10 * CPB + 1)) begin
      mbyte = mq.pop_front();
      mfp   = mn;
      mhas  = 1'b1;
    end
    if (wr && a[31] && a[3:2] == 2'd0) begin
      if (full_b) movf = 1'b1;
      else        mq.push_back(wd[7:0]);
    end
    if (wr && a[31] && a[3:2] == 2'd1 && wd[2]) movf = 1'b0;
    if (wr && a[31] && a[3:2] == 2'd2) mcnt = wd;
    else                               mcnt = mcnt + 32'd1;
    if (wr && !a[31]) mram[ram_key(a)] = wd;
  endtask

  // line level after edge mn: 1 start slot, 8 data slots LSB first, 1 stop slot
  function automatic logic model_tx();
    int slot;
    if (mhas && mn < mfp + 10 * CPB) begin
      slot = (mn - mfp) / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return mbyte[slot-1];
      return 1'b1;
    end
    return 1'b1;
  endfunction

  // called at a falling edge; returns at the next falling edge
  task automatic cyc(input logic en, input logic rd, input logic [31:0] a, input logic [31:0] wd);
    core_en    = en;
    core_read  = rd;
    core_addr  = a;
    core_wdata = wd;
    if (en && rd) mrd = model_read(a);
    if (en) rdq.push_back(mrd);
    model_edge(en, rd, a, wd);
    txq.push_back(model_tx());
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // asynchronous reset asserted between a rising and falling edge
  task automatic reset_pulse(input int k);
    core_en   = 1'b0;
    core_read = 1'b0;
    model_edge(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    txq.push_back(1'b1);
    @(negedge clk);
    repeat (k) begin
      txq.push_back(1'b1);
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  // monitor: sample the access at the rising edge, compare at the falling edge
  always begin
    logic        acc;
    logic [31:0] a;
    logic [31:0] e;
    logic        et;
    @(posedge clk);
    acc = core_en && rst_n;
    a   = core_addr;
    @(negedge clk);
    if (txq.size() > 0) begin
      et = txq.pop_front();
      checks++;
      if (uart_tx !== et) begin
        errors++;
        $display("FAIL uart_tx t=%0t got=%b want=%b", $time, uart_tx, et);
      end
    end
    if (!rst_n) begin
      checks++;
      if (core_rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata t=%0t got=%h want=00000000", $time, core_rdata);
      end
    end
    if (acc) begin
      checks++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL rdata addr=%h got=%h want=<none queued>", a, core_rdata);
      end else begin
        e = rdq.pop_front();
        if (core_rdata !== e) begin
          errors++;
          $display("FAIL rdata addr=%h got=%h want=%h", a, core_rdata, e);
        end else begin
          $display("txn addr=%h rdata=%h", a, core_rdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] ma;
    int op;

    rst_n = 1'b0;
    core_en = 1'b0;
    core_read = 1'b0;
    core_addr = '0;
    core_wdata = '0;
    model_reset();
    repeat (3) begin
      txq.push_back(1'b1);
      @(negedge clk);
    end
    rst_n = 1'b1;

    // RAM access, alias of byte offset and wrap beyond RAM size
    cyc(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b1, 32'h10, 32'h0);
    cyc(1'b1, 1'b1, 32'h13, 32'h0);
    cyc(1'b1, 1'b1, 32'h1010, 32'h0);
    // read data holds across a write
    cyc(1'b1, 1'b1, 32'h10, 32'h0);
    cyc(1'b1, 1'b0, 32'h10, 32'h1);
    idle(2);
    cyc(1'b1, 1'b0, 32'h8000_000C, 32'h1234_5678);
    cyc(1'b1, 1'b1, 32'h10, 32'h0);
    cyc(1'b1, 1'b1, 32'h8000_000C, 32'h0);

    // counter load and wrap
    cyc(1'b1, 1'b0, 32'h8000_0008, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b1, 32'h8000_0008, 32'h0);
    cyc(1'b1, 1'b1, 32'h8000_0008, 32'h0);

    // single UART frame
    cyc(1'b1, 1'b0, 32'h8000_0000, 32'h55);
    idle(50);

    // overflow and clear
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h8000_0000, 32'(8'hA0 + i));
    cyc(1'b1, 1'b1, 32'h8000_0004, 32'h0);
    cyc(1'b1, 1'b0, 32'h8000_0004, 32'h4);
    cyc(1'b1, 1'b1, 32'h8000_0004, 32'h0);
    idle(100);

    // reset in the middle of a frame with bytes still queued
    reset_pulse(2);
    cyc(1'b1, 1'b0, 32'h8000_0000, 32'h00);
    cyc(1'b1, 1'b0, 32'h8000_0000, 32'h11);
    cyc(1'b1, 1'b0, 32'h8000_0000, 32'h22);
    cyc(1'b1, 1'b0, 32'h8000_0000, 32'h33);
    idle(10);
    reset_pulse(3);
    cyc(1'b1, 1'b1, 32'h8000_0004, 32'h0);
    idle(60);

    // randomized mix over 16 RAM words and all MMIO registers
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'(i * 4), $urandom());
    for (int i = 0; i < 600; i++) begin
      r  = $urandom();
      wd = $urandom();
      op = $urandom_range(0, 9);
      ra = {1'b0, r[30:12], 6'b0, r[5:2], r[1:0]};
      ma = {1'b1, r[30:4], 2'b00, r[1:0]};
      case (op)
        0, 1:    cyc(1'b0, 1'b0, ra, wd);
        2, 3, 4: cyc(1'b1, 1'b1, ra, wd);
        5, 6:    cyc(1'b1, 1'b0, ra, wd);
        7: begin
          ma[3:2] = 2'd0;
          cyc(1'b1, r[31] & r[30], ma, wd);
        end
        8: begin
          ma[3:2] = 2'd1;
          cyc(1'b1, r[31], ma, wd);
        end
        default: begin
          ma[3:2] = {1'b1, r[29]};
          cyc(1'b1, r[31], ma, wd);
        end
      endcase
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
